pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. It generates the PC and pipeline-register enable/flush controls.
- It arbitrates between three conditions in fixed priority: data-memory wait, taken-branch flush, and load-use stall.
- Instruction-class decode for register usage uses the same opcode set as the immediate generator: OP-IMM, LUI, LOAD, STORE, BRANCH, plus OP.
- It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..3 (2 for builds without MEM->EX forwarding).
- MEM_TIMEOUT, 64, maximum consecutive wait cycles before abandoning a memory access; must be ≥2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_inst  in  32  instruction in ID; uses [6:0] opcode, [19:15] rs1, [24:20] rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_br_taken  in  1  EX resolved a taken branch this cycle.
- mem_req  in  1  MEM stage holds a load/store access.
- dmem_ready  in  1  data memory completes the access this cycle.
- clr_cnt  in  1  synchronous clear of the counters and mem_err.
- pc_en  out  1  PC register update enable.
- pc_sel  out  1  1 = load branch target, 0 = PC+4.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (NOP) into the register.
- mem_err  out  1  sticky; a memory access timed out.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Reset: state=RUN, lu_cnt=0, wait_cnt=0, counters=0, mem_err=0.
- While rst_n=0, all enables, flushes and pc_sel are 0.
- Outputs are combinational from state and inputs (Mealy). The default is all enables 1, flushes 0, pc_sel 0.
- Register-usage decode:
  - rs1 is used by opcodes 0010011, 0000011, 0100011, 1100011, 0110011.
  - rs2 is used by 0100011, 1100011, 0110011.
  - LUI and unknown opcodes use neither.
- hazard = ex_mem_read & ex_rd≠0 & ((use_rs1 & ex_rd==rs1) | (use_rs2 & ex_rd==rs2)).
- memhold = mem_req & ~dmem_ready.
- RUN, evaluated in priority order:
  1. memhold: all enables 0. Next state MEM_WAIT; wait_cnt←1; stall_cnt++.
  2. ex_br_taken: pc_sel=1, pc_en=1, ifid_flush=1, idex_flush=1. Stay in RUN; flush_cnt++. A coincident hazard is ignored because the ID instruction is squashed.
  3. hazard: pc_en=0, ifid_en=0, idex_flush=1; stall_cnt++.
     - If LU_STALL_CYCLES>1: go to LU_STALL with lu_cnt←LU_STALL_CYCLES-1.
     - Otherwise stay in RUN.
- LU_STALL:
  - Normally: pc_en=0, ifid_en=0, idex_flush=1; stall_cnt++; lu_cnt--. Exit to RUN on the cycle lu_cnt reaches 1.
  - If memhold: all enables 0, no flush, lu_cnt holds, state holds; stall_cnt++.
  - ex_br_taken is ignored in LU_STALL (EX holds a bubble).
- MEM_WAIT:
  - While memhold: all enables 0; wait_cnt++; stall_cnt++.
  - On dmem_ready=1: outputs as RUN with memhold=0 (branch/hazard rules apply); next state per those rules.
  - If wait_cnt==MEM_TIMEOUT with no ready: set mem_err, advance the pipeline (all enables 1) and return to RUN. The access is dropped.
- Counters saturate at 2^CNT_W-1.
- clr_cnt has priority over increment in the same cycle. It does not affect the FSM.
- Asynchronous reset mid-stall or mid-wait returns immediately to the reset values; no partial state survives.

Test Plan:
- Load-use: EX has a load with ex_rd=5; ID has id_inst=0x00528293 (addi x5,x5,5). Required: pc_en=0, ifid_en=0, idex_flush=1 for exactly LU_STALL_CYCLES cycles (1 and 2 both checked), then pc_en=1; stall_cnt=LU_STALL_CYCLES.
- No false hazard: ex_rd=0 with a load, or ID=LUI 0x000052B7 with ex_rd=5. Required: no stall, stall_cnt stays 0.
- Branch priority: ex_br_taken=1 with a simultaneous load-use hazard. Required: pc_sel=1, ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1 with dmem_ready low for 3 cycles, plus a branch on the ready cycle. Required: all enables 0 for 3 cycles, then pc_sel=1 on the ready cycle; stall_cnt=3, flush_cnt=1.
- Timeout with MEM_TIMEOUT=4: dmem_ready held 0. Required: mem_err=1 at wait_cnt==4, the pipeline advances and the state returns to RUN. clr_cnt=1 then clears mem_err and both counters.
- Reset mid-LU_STALL (LU_STALL_CYCLES=3): drop rst_n in the 2nd stall cycle. Required: outputs go to 0 immediately. After release: RUN, counters 0, no residual stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: PC/pipeline-register
// enables and flushes, arbitrating memory wait > taken branch > load-use stall.
module pipe_hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 64,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0]        LU_INIT  = 2'(LU_STALL_CYCLES - 1);

    state_t            state, state_n;
    logic [1:0]        lu_cnt, lu_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       use_rs1, use_rs2, hazard, memhold;
    logic       stall_inc, flush_inc, err_set, do_run;
    logic       en_pc, en_ifid, en_rest, sel_pc, fl_ifid, fl_idex;
    logic       unused_bits;

    assign opcode      = id_inst[6:0];
    assign rs1         = id_inst[19:15];
    assign rs2         = id_inst[24:20];
    assign unused_bits = &{1'b0, id_inst[31:25], id_inst[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0010011, 7'b0000011:             use_rs1 = 1'b1;
            7'b0100011, 7'b1100011, 7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign hazard  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
    assign memhold = mem_req && !dmem_ready;

    always_comb begin
        state_n   = state;
        lu_n      = lu_cnt;
        wait_n    = wait_cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        err_set   = 1'b0;
        do_run    = 1'b0;
        en_pc     = 1'b1;
        en_ifid   = 1'b1;
        en_rest   = 1'b1;
        sel_pc    = 1'b0;
        fl_ifid   = 1'b0;
        fl_idex   = 1'b0;

        case (state)
            ST_RUN: do_run = 1'b1;
            ST_LU_STALL: begin
                en_pc     = 1'b0;
                en_ifid   = 1'b0;
                stall_inc = 1'b1;
                if (memhold) begin
                    en_rest = 1'b0;
                end else begin
                    fl_idex = 1'b1;
                    if (lu_cnt <= 2'd1) begin
                        lu_n    = 2'd0;
                        state_n = ST_RUN;
                    end else begin
                        lu_n = lu_cnt - 2'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (memhold) begin
                    // Timed-out access is dropped and the pipeline moves on.
                    if (wait_cnt >= WAIT_MAX) begin
                        err_set = 1'b1;
                        wait_n  = '0;
                        state_n = ST_RUN;
                    end else begin
                        en_pc     = 1'b0;
                        en_ifid   = 1'b0;
                        en_rest   = 1'b0;
                        wait_n    = wait_cnt + WAIT_W'(1);
                        stall_inc = 1'b1;
                    end
                end else begin
                    wait_n = '0;
                    do_run = 1'b1;
                end
            end
            default: state_n = ST_RUN;
        endcase

        if (do_run) begin
            state_n = ST_RUN;
            if (memhold) begin
                en_pc     = 1'b0;
                en_ifid   = 1'b0;
                en_rest   = 1'b0;
                state_n   = ST_MEM_WAIT;
                wait_n    = WAIT_W'(1);
                stall_inc = 1'b1;
            end else if (ex_br_taken) begin
                // ID instruction is squashed, so a coincident hazard is moot.
                sel_pc    = 1'b1;
                fl_ifid   = 1'b1;
                fl_idex   = 1'b1;
                flush_inc = 1'b1;
            end else if (hazard) begin
                en_pc     = 1'b0;
                en_ifid   = 1'b0;
                fl_idex   = 1'b1;
                stall_inc = 1'b1;
                if (LU_STALL_CYCLES > 1) begin
                    state_n = ST_LU_STALL;
                    lu_n    = LU_INIT;
                end
            end
        end
    end

    // Outputs are forced low while reset is asserted.
    assign pc_en      = rst_n & en_pc;
    assign pc_sel     = rst_n & sel_pc;
    assign ifid_en    = rst_n & en_ifid;
    assign idex_en    = rst_n & en_rest;
    assign exmem_en   = rst_n & en_rest;
    assign memwb_en   = rst_n & en_rest;
    assign ifid_flush = rst_n & fl_ifid;
    assign idex_flush = rst_n & fl_idex;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            lu_cnt   <= 2'd0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            lu_cnt   <= lu_n;
            wait_cnt <= wait_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (err_set) mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three parameterisations share one stimulus
// stream; expected control vectors go through a queue and are checked per cycle.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] C_RUN   = 8'b1011_1100;
    localparam logic [7:0] C_STALL = 8'b0001_1101;
    localparam logic [7:0] C_HOLD  = 8'b0000_0000;
    localparam logic [7:0] C_BR    = 8'b1111_1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_inst = 32'h0000_0013;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_mem_read = 1'b0, ex_br_taken = 1'b0;
    logic        mem_req = 1'b0, dmem_ready = 1'b0, clr_cnt = 1'b0;

    logic [2:0]  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
    logic [2:0]  ifid_flush, idex_flush, mem_err;
    logic [3:0]  a_stall, a_flush;
    logic [15:0] b_stall, b_flush, c_stall, c_flush;
    logic [1:0]  dbg [3];

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(64), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .clr_cnt(clr_cnt), .pc_en(pc_en[0]), .pc_sel(pc_sel[0]),
        .ifid_en(ifid_en[0]), .idex_en(idex_en[0]), .exmem_en(exmem_en[0]),
        .memwb_en(memwb_en[0]), .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
        .mem_err(mem_err[0]), .stall_cnt(a_stall), .flush_cnt(a_flush), .dbg_state(dbg[0]));

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .clr_cnt(clr_cnt), .pc_en(pc_en[1]), .pc_sel(pc_sel[1]),
        .ifid_en(ifid_en[1]), .idex_en(idex_en[1]), .exmem_en(exmem_en[1]),
        .memwb_en(memwb_en[1]), .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
        .mem_err(mem_err[1]), .stall_cnt(b_stall), .flush_cnt(b_flush), .dbg_state(dbg[1]));

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .clr_cnt(clr_cnt), .pc_en(pc_en[2]), .pc_sel(pc_sel[2]),
        .ifid_en(ifid_en[2]), .idex_en(idex_en[2]), .exmem_en(exmem_en[2]),
        .memwb_en(memwb_en[2]), .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]),
        .mem_err(mem_err[2]), .stall_cnt(c_stall), .flush_cnt(c_flush), .dbg_state(dbg[2]));

    function automatic logic [7:0] ctrl(input int i);
        return {pc_en[i], pc_sel[i], ifid_en[i], idex_en[i], exmem_en[i], memwb_en[i],
                ifid_flush[i], idex_flush[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_inst = 32'h0000_0013; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic set_hazard(input logic [31:0] inst);
        id_inst = inst; ex_rd = 5'd5; ex_mem_read = 1'b1;
    endtask

    // Inputs are set at posedge+1; outputs compared at the following negedge.
    task automatic step(input string tag, input logic [7:0] ea, eb, ec);
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        exp_q.push_back(ec);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s[%0d]", tag, i), {24'd0, ctrl(i)}, {24'd0, exp_q.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic cnts(input string tag, input int sa, sb, sc, fa, fb, fc);
        check({tag, "_stall_a"}, {28'd0, a_stall}, sa);
        check({tag, "_stall_b"}, {16'd0, b_stall}, sb);
        check({tag, "_stall_c"}, {16'd0, c_stall}, sc);
        check({tag, "_flush_a"}, {28'd0, a_flush}, fa);
        check({tag, "_flush_b"}, {16'd0, b_flush}, fb);
        check({tag, "_flush_c"}, {16'd0, c_flush}, fc);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        idle();
        #2;
        for (int i = 0; i < 3; i++) check($sformatf("rst_ctrl[%0d]", i), {24'd0, ctrl(i)}, 32'd0);
        do_reset();
        cnts("rst", 0, 0, 0, 0, 0, 0);
        check("rst_err", {29'd0, mem_err}, 32'd0);
        check("rst_state_c", {30'd0, dbg[2]}, 32'd0);

        // Load-use with addi x5,x5,5: 1, 2 and 3 bubbles
        set_hazard(32'h0052_8293);
        step("lu1", C_STALL, C_STALL, C_STALL);
        idle();
        step("lu2", C_RUN, C_STALL, C_STALL);
        step("lu3", C_RUN, C_RUN, C_STALL);
        step("lu4", C_RUN, C_RUN, C_RUN);
        cnts("lu", 1, 2, 3, 0, 0, 0);

        // No false hazards: x0 destination, LUI, JAL with matching rs1 field
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_inst = 32'h0052_8293;
        step("nf_x0", C_RUN, C_RUN, C_RUN);
        ex_rd = 5'd5; id_inst = 32'h0000_52B7;
        step("nf_lui", C_RUN, C_RUN, C_RUN);
        id_inst = 32'h0002_806F;
        step("nf_jal", C_RUN, C_RUN, C_RUN);
        cnts("nf", 0, 0, 0, 0, 0, 0);
        // Store uses rs2
        id_inst = 32'h0050_2023;
        step("sw1", C_STALL, C_STALL, C_STALL);
        idle();
        step("sw2", C_RUN, C_STALL, C_STALL);
        step("sw3", C_RUN, C_RUN, C_STALL);
        cnts("sw", 1, 2, 3, 0, 0, 0);

        // Branch beats a coincident load-use hazard
        do_reset();
        set_hazard(32'h0052_8293);
        ex_br_taken = 1'b1;
        step("br1", C_BR, C_BR, C_BR);
        idle();
        step("br2", C_RUN, C_RUN, C_RUN);
        cnts("br", 0, 0, 0, 1, 1, 1);

        // Memory wait of 3 cycles, branch on the ready cycle
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("mw%0d", i), C_HOLD, C_HOLD, C_HOLD);
        dmem_ready = 1'b1; ex_br_taken = 1'b1;
        step("mw_rdy", C_BR, C_BR, C_BR);
        idle();
        step("mw_after", C_RUN, C_RUN, C_RUN);
        cnts("mw", 3, 3, 3, 1, 1, 1);

        // Timeout (b, c have MEM_TIMEOUT=4), then clear with a coincident branch
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("to%0d", i), C_HOLD, C_HOLD, C_HOLD);
        step("to_fire", C_HOLD, C_RUN, C_RUN);
        check("to_err", {29'd0, mem_err}, 32'b110);
        cnts("to", 5, 4, 4, 0, 0, 0);
        idle();
        step("to_after", C_RUN, C_RUN, C_RUN);
        check("to_state_b", {30'd0, dbg[1]}, 32'd0);
        clr_cnt = 1'b1; ex_br_taken = 1'b1;
        step("clr", C_BR, C_BR, C_BR);
        check("clr_err", {29'd0, mem_err}, 32'd0);
        cnts("clr", 0, 0, 0, 0, 0, 0);
        idle();

        // Memory hold inside a load-use stall freezes the bubble count
        do_reset();
        set_hazard(32'h0052_8293);
        step("lh1", C_STALL, C_STALL, C_STALL);
        idle();
        mem_req = 1'b1;
        step("lh2", C_HOLD, C_HOLD, C_HOLD);
        mem_req = 1'b0;
        step("lh3", C_RUN, C_STALL, C_STALL);
        step("lh4", C_RUN, C_RUN, C_STALL);
        step("lh5", C_RUN, C_RUN, C_RUN);
        cnts("lh", 2, 3, 4, 0, 0, 0);

        // Saturation of the 4-bit counter and repeated timeouts
        do_reset();
        mem_req = 1'b1;
        for (int i = 1; i <= 20; i++)
            step($sformatf("sat%0d", i), C_HOLD, (i % 5 == 0) ? C_RUN : C_HOLD,
                 (i % 5 == 0) ? C_RUN : C_HOLD);
        cnts("sat", 15, 16, 16, 0, 0, 0);
        check("sat_err", {29'd0, mem_err}, 32'b110);
        idle();
        step("sat_after", C_RUN, C_RUN, C_RUN);

        // Asynchronous reset in the second cycle of a 3-cycle load-use stall
        do_reset();
        set_hazard(32'h0052_8293);
        step("rl1", C_STALL, C_STALL, C_STALL);
        idle();
        check("rl_pre", {24'd0, ctrl(2)}, {24'd0, C_STALL});
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("rl_ctrl[%0d]", i), {24'd0, ctrl(i)}, 32'd0);
        check("rl_state_c", {30'd0, dbg[2]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("rl_post1", C_RUN, C_RUN, C_RUN);
        step("rl_post2", C_RUN, C_RUN, C_RUN);
        cnts("rl", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
